// File: rtl/game_flow_controller.sv
// ---------------------------------------------------------------------------
// game_flow_controller
//
// Top-level sequencer for the breakout game. Turns the per-frame video pulse
// into a fixed-length game-logic update window, tracks lives and level, and
// runs the attract / serve / play / lost / level-clear / game-over flow.
// Also issues the block-reload and ball-respawn commands.
//
// Parameters
//   STEPS_PER_FRAME    cycles in each game-logic update window
//   LIVES_INIT         lives loaded at new game (1..3)
//   LOST_DELAY_FRAMES  frames frozen after a lost ball (1..255)
//   LEVEL_DELAY_FRAMES frames frozen after a cleared level (1..255)
//   MAX_LEVEL          level saturation value (0..15)
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst_n          synchronous active-low reset
//   i_frame_start    one-cycle pulse per video frame
//   i_btn_release    debounced release button (rising edge used)
//   i_btn_pause      debounced pause button (rising edge used)
//   i_ball_lost      one-cycle pulse when the ball passes the paddle
//   i_block_state    live block bitmap; all-zero means level cleared
//   o_start_update   one-cycle pulse starting a game-logic update
//   o_update_active  high for STEPS_PER_FRAME cycles after o_start_update
//   o_reload_blocks  one-cycle pulse restoring the block pattern
//   o_respawn_ball   one-cycle pulse placing the ball on the paddle
//   o_lives          remaining lives
//   o_level          current level, 0-based
//   o_game_state     0 ATTRACT, 1 SERVE, 2 PLAY, 3 LOST_WAIT,
//                    4 LEVEL_CLEAR, 5 GAME_OVER
//   o_paused         pause flag
//   o_frame_count    free-running frame counter (wraps)
// ---------------------------------------------------------------------------
module game_flow_controller #(
    parameter int unsigned STEPS_PER_FRAME    = 12,
    parameter int unsigned LIVES_INIT         = 3,
    parameter int unsigned LOST_DELAY_FRAMES  = 60,
    parameter int unsigned LEVEL_DELAY_FRAMES = 90,
    parameter int unsigned MAX_LEVEL          = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_start,
    input  logic        i_btn_release,
    input  logic        i_btn_pause,
    input  logic        i_ball_lost,
    input  logic [71:0] i_block_state,
    output logic        o_start_update,
    output logic        o_update_active,
    output logic        o_reload_blocks,
    output logic        o_respawn_ball,
    output logic [1:0]  o_lives,
    output logic [3:0]  o_level,
    output logic [2:0]  o_game_state,
    output logic        o_paused,
    output logic [15:0] o_frame_count
);

    localparam int unsigned STEP_W =
        (STEPS_PER_FRAME > 1) ? $clog2(STEPS_PER_FRAME) : 1;

    typedef enum logic [2:0] {
        ST_ATTRACT     = 3'd0,
        ST_SERVE       = 3'd1,
        ST_PLAY        = 3'd2,
        ST_LOST_WAIT   = 3'd3,
        ST_LEVEL_CLEAR = 3'd4,
        ST_GAME_OVER   = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_paused;
    logic [1:0]          r_lives;
    logic [3:0]          r_level;
    logic [15:0]         r_frame_count;
    logic [7:0]          r_delay;
    logic                r_reload_blocks;
    logic                r_respawn_ball;
    logic                r_rel_prev;
    logic                r_pause_prev;
    logic                r_start_update;
    logic                r_update_active;
    logic [STEP_W-1:0]   r_step;

    logic w_rel_edge;
    logic w_pause_edge;
    logic w_blocks_empty;
    logic w_in_game;
    logic w_last_step;
    logic w_window_open;
    logic w_accept_frame;

    assign w_rel_edge     = i_btn_release & ~r_rel_prev;
    assign w_pause_edge   = i_btn_pause & ~r_pause_prev;
    assign w_blocks_empty = (i_block_state == '0);
    assign w_in_game      = (r_state == ST_SERVE) || (r_state == ST_PLAY);
    assign w_last_step    = (r_step == STEP_W'(STEPS_PER_FRAME - 1));

    // The window counts as closed on its final active cycle, so a frame
    // sampled there starts a new update right after UPDATE_ACTIVE drops.
    assign w_window_open  = r_start_update | (r_update_active & ~w_last_step);
    assign w_accept_frame = i_frame_start & w_in_game & ~r_paused & ~w_window_open;

    // -----------------------------------------------------------------------
    // Button history (reset to 1 so a button held through reset is no edge)
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rel_prev   <= 1'b1;
            r_pause_prev <= 1'b1;
        end else begin
            r_rel_prev   <= i_btn_release;
            r_pause_prev <= i_btn_pause;
        end
    end

    // -----------------------------------------------------------------------
    // Update window scheduler; runs independently of the flow state so an
    // open window always completes.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_start_update  <= 1'b0;
            r_update_active <= 1'b0;
            r_step          <= '0;
        end else begin
            r_start_update <= w_accept_frame;
            if (r_start_update) begin
                r_update_active <= 1'b1;
                r_step          <= '0;
            end else if (r_update_active) begin
                if (w_last_step) begin
                    r_update_active <= 1'b0;
                end
                r_step <= r_step + STEP_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Game flow FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state         <= ST_ATTRACT;
            r_paused        <= 1'b0;
            r_lives         <= 2'(LIVES_INIT);
            r_level         <= '0;
            r_frame_count   <= '0;
            r_delay         <= '0;
            r_reload_blocks <= 1'b0;
            r_respawn_ball  <= 1'b0;
        end else begin
            r_reload_blocks <= 1'b0;
            r_respawn_ball  <= 1'b0;

            if (i_frame_start) begin
                r_frame_count <= r_frame_count + 16'd1;
            end

            case (r_state)
                ST_ATTRACT: begin
                    if (w_rel_edge) begin
                        r_reload_blocks <= 1'b1;
                        r_respawn_ball  <= 1'b1;
                        r_lives         <= 2'(LIVES_INIT);
                        r_level         <= '0;
                        r_state         <= ST_SERVE;
                    end
                end

                ST_SERVE: begin
                    if (w_pause_edge) begin
                        r_paused <= ~r_paused;
                    end
                    if (w_rel_edge && !r_paused) begin
                        r_state <= ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    // Empty board takes priority over a simultaneous lost ball.
                    if (w_blocks_empty) begin
                        r_delay  <= 8'(LEVEL_DELAY_FRAMES);
                        r_paused <= 1'b0;
                        r_state  <= ST_LEVEL_CLEAR;
                    end else if (i_ball_lost) begin
                        r_paused <= 1'b0;
                        if (r_lives <= 2'd1) begin
                            r_lives <= '0;
                            r_state <= ST_GAME_OVER;
                        end else begin
                            r_lives <= r_lives - 2'd1;
                            r_delay <= 8'(LOST_DELAY_FRAMES);
                            r_state <= ST_LOST_WAIT;
                        end
                    end else if (w_pause_edge) begin
                        r_paused <= ~r_paused;
                    end
                end

                ST_LOST_WAIT: begin
                    if (i_frame_start) begin
                        if (r_delay <= 8'd1) begin
                            r_delay        <= '0;
                            r_respawn_ball <= 1'b1;
                            r_state        <= ST_SERVE;
                        end else begin
                            r_delay <= r_delay - 8'd1;
                        end
                    end
                end

                ST_LEVEL_CLEAR: begin
                    if (i_frame_start) begin
                        if (r_delay <= 8'd1) begin
                            r_delay         <= '0;
                            r_reload_blocks <= 1'b1;
                            r_respawn_ball  <= 1'b1;
                            if (r_level >= 4'(MAX_LEVEL)) begin
                                r_level <= 4'(MAX_LEVEL);
                            end else begin
                                r_level <= r_level + 4'd1;
                            end
                            r_state <= ST_SERVE;
                        end else begin
                            r_delay <= r_delay - 8'd1;
                        end
                    end
                end

                ST_GAME_OVER: begin
                    if (w_rel_edge) begin
                        r_state <= ST_ATTRACT;
                    end
                end

                default: begin
                    r_paused <= 1'b0;
                    r_state  <= ST_ATTRACT;
                end
            endcase
        end
    end

    assign o_start_update  = r_start_update;
    assign o_update_active = r_update_active;
    assign o_reload_blocks = r_reload_blocks;
    assign o_respawn_ball  = r_respawn_ball;
    assign o_lives         = r_lives;
    assign o_level         = r_level;
    assign o_game_state    = r_state;
    assign o_paused        = r_paused;
    assign o_frame_count   = r_frame_count;

endmodule

// File: tb/tb_game_flow_controller.sv
// ---------------------------------------------------------------------------
// tb_game_flow_controller
//
// Drives directed scenarios followed by randomized stimulus into
// game_flow_controller and compares every output, every cycle, against a
// behavioural model kept here. Key scenario points also get explicit checks.
// ---------------------------------------------------------------------------
module tb_game_flow_controller;

    localparam int S          = 12;
    localparam int L_INIT     = 3;
    localparam int LOST_D     = 60;
    localparam int LEVEL_D    = 90;
    localparam int MAX_LVL    = 15;

    localparam int M_ATTRACT  = 0;
    localparam int M_SERVE    = 1;
    localparam int M_PLAY     = 2;
    localparam int M_LOST     = 3;
    localparam int M_CLEAR    = 4;
    localparam int M_OVER     = 5;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic        btn_release;
    logic        btn_pause;
    logic        ball_lost;
    logic [71:0] block_state;
    logic        start_update;
    logic        update_active;
    logic        reload_blocks;
    logic        respawn_ball;
    logic [1:0]  lives;
    logic [3:0]  level;
    logic [2:0]  game_state;
    logic        paused;
    logic [15:0] frame_count;

    game_flow_controller #(
        .STEPS_PER_FRAME    (S),
        .LIVES_INIT         (L_INIT),
        .LOST_DELAY_FRAMES  (LOST_D),
        .LEVEL_DELAY_FRAMES (LEVEL_D),
        .MAX_LEVEL          (MAX_LVL)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_frame_start   (frame_start),
        .i_btn_release   (btn_release),
        .i_btn_pause     (btn_pause),
        .i_ball_lost     (ball_lost),
        .i_block_state   (block_state),
        .o_start_update  (start_update),
        .o_update_active (update_active),
        .o_reload_blocks (reload_blocks),
        .o_respawn_ball  (respawn_ball),
        .o_lives         (lives),
        .o_level         (level),
        .o_game_state    (game_state),
        .o_paused        (paused),
        .o_frame_count   (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int edge_no    = 0;
    int m_state    = M_ATTRACT;
    int m_paused   = 0;
    int m_lives    = L_INIT;
    int m_level    = 0;
    int m_fc       = 0;
    int m_delay    = 0;
    int m_reload   = 0;
    int m_respawn  = 0;
    int m_win      = -1000000;  // edge at which the last accepted frame was sampled
    int m_prev_rel = 1;
    int m_prev_pau = 1;

    function automatic bit in_game(input int st);
        return (st == M_SERVE) || (st == M_PLAY);
    endfunction

    // Window spans the S edges following the accepting edge.
    function automatic bit win_covers(input int e);
        return (e > m_win) && (e <= m_win + S);
    endfunction

    task automatic model_step();
        int nxt;
        bit rel_e;
        bit pau_e;
        edge_no++;
        if (!rst_n) begin
            m_state = M_ATTRACT; m_paused = 0; m_lives = L_INIT; m_level = 0;
            m_fc = 0; m_delay = 0; m_reload = 0; m_respawn = 0;
            m_win = -1000000; m_prev_rel = 1; m_prev_pau = 1;
            return;
        end
        rel_e = btn_release && (m_prev_rel == 0);
        pau_e = btn_pause && (m_prev_pau == 0);
        m_prev_rel = int'(btn_release);
        m_prev_pau = int'(btn_pause);
        m_reload  = 0;
        m_respawn = 0;
        if (frame_start) m_fc = (m_fc + 1) % 65536;
        if (frame_start && in_game(m_state) && m_paused == 0 && !win_covers(edge_no))
            m_win = edge_no;

        nxt = m_state;
        if (m_state == M_ATTRACT) begin
            if (rel_e) begin
                m_reload = 1; m_respawn = 1; m_lives = L_INIT; m_level = 0; nxt = M_SERVE;
            end
        end else if (m_state == M_SERVE) begin
            if (rel_e && m_paused == 0) nxt = M_PLAY;
        end else if (m_state == M_PLAY) begin
            if (block_state == 72'd0) begin
                m_delay = LEVEL_D; nxt = M_CLEAR;
            end else if (ball_lost) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) nxt = M_OVER;
                else begin m_delay = LOST_D; nxt = M_LOST; end
            end
        end else if (m_state == M_LOST || m_state == M_CLEAR) begin
            if (frame_start) begin
                m_delay = m_delay - 1;
                if (m_delay <= 0) begin
                    m_respawn = 1;
                    if (m_state == M_CLEAR) begin
                        m_reload = 1;
                        m_level  = (m_level + 1 > MAX_LVL) ? MAX_LVL : m_level + 1;
                    end
                    nxt = M_SERVE;
                end
            end
        end else if (m_state == M_OVER) begin
            if (rel_e) nxt = M_ATTRACT;
        end
        if (pau_e && in_game(m_state)) m_paused = 1 - m_paused;
        if (!in_game(nxt)) m_paused = 0;
        m_state = nxt;
    endtask

    task automatic compare_all();
        chk("start_update",  32'(start_update),  32'(edge_no == m_win));
        chk("update_active", 32'(update_active), 32'(win_covers(edge_no)));
        chk("reload_blocks", 32'(reload_blocks), 32'(m_reload));
        chk("respawn_ball",  32'(respawn_ball),  32'(m_respawn));
        chk("lives",         32'(lives),         32'(m_lives));
        chk("level",         32'(level),         32'(m_level));
        chk("game_state",    32'(game_state),    32'(m_state));
        chk("paused",        32'(paused),        32'(m_paused));
        chk("frame_count",   32'(frame_count),   32'(m_fc));
    endtask

    // One clock: model and DUT both see the same inputs at the edge,
    // outputs are compared at the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [71:0] rand_blocks();
        logic [71:0] v;
        int idx;
        v[31:0]  = $urandom();
        v[63:32] = $urandom();
        v[71:64] = 8'($urandom());
        if ($urandom_range(3) == 0) v = '0;
        idx = int'($urandom_range(71));
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic frames(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0;
            repeat (gap - 1) tick();
        end
    endtask

    task automatic press_release();
        btn_release = 1'b0; tick();
        btn_release = 1'b1; tick();
    endtask

    task automatic press_pause();
        btn_pause = 1'b0; tick();
        btn_pause = 1'b1; tick();
    endtask

    // Pulses frames while the DUT stays in state st; returns frames used.
    task automatic frames_while_state(input int st, input int gap, input int max_n, output int n);
        n = 0;
        while (int'(game_state) == st && n < max_n) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0;
            n++;
            if (int'(game_state) != st) break;
            repeat (gap - 1) tick();
        end
    endtask

    int n;
    int starts;
    int actives;
    int lives_before;

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        btn_release = 1'b1;
        btn_pause   = 1'b0;
        ball_lost   = 1'b0;
        block_state = '1;

        // Reset with release held; held release must not start a game.
        repeat (3) tick();
        chk("rst_state", 32'(game_state), M_ATTRACT);
        chk("rst_lives", 32'(lives), L_INIT);
        chk("rst_fc", 32'(frame_count), 0);
        rst_n = 1'b1;
        frames(5, 20);
        chk("held_rel_state", 32'(game_state), M_ATTRACT);
        press_release();
        chk("new_reload", 32'(reload_blocks), 1);
        chk("new_respawn", 32'(respawn_ball), 1);
        chk("new_lives", 32'(lives), 3);
        chk("new_state", 32'(game_state), M_SERVE);
        tick();
        chk("reload_one_cycle", 32'(reload_blocks), 0);

        // Update window timing and a dropped second frame.
        press_release();
        chk("to_play", 32'(game_state), M_PLAY);
        repeat (3) tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("start_pulse", 32'(start_update), 1);
        starts = 0; actives = 0;
        for (int i = 1; i <= 14; i++) begin
            frame_start = (i == 4);
            tick();
            starts  += int'(start_update);
            actives += int'(update_active);
        end
        frame_start = 1'b0;
        chk("win_len", 32'(actives), S);
        chk("dropped_frame", 32'(starts), 0);
        repeat (10) tick();

        // Pause stops updates; second edge resumes them.
        press_pause();
        chk("paused_set", 32'(paused), 1);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0;
            starts += int'(start_update);
            for (int j = 0; j < 19; j++) begin tick(); starts += int'(start_update); end
        end
        chk("paused_no_update", 32'(starts), 0);
        press_pause();
        chk("paused_clr", 32'(paused), 0);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("resume_start", 32'(start_update), 1);
        repeat (20) tick();

        // Lost ball with 3 lives, then countdown.
        ball_lost = 1'b1; tick(); ball_lost = 1'b0;
        chk("lost_lives", 32'(lives), 2);
        chk("lost_state", 32'(game_state), M_LOST);
        frames_while_state(M_LOST, 4, 100, n);
        chk("lost_frames", 32'(n), LOST_D);
        chk("lost_respawn", 32'(respawn_ball), 1);
        chk("lost_serve", 32'(game_state), M_SERVE);

        // Down to game over.
        press_release();
        ball_lost = 1'b1; tick(); ball_lost = 1'b0;
        frames_while_state(M_LOST, 3, 100, n);
        press_release();
        chk("one_life", 32'(lives), 1);
        ball_lost = 1'b1; tick(); ball_lost = 1'b0;
        chk("over_lives", 32'(lives), 0);
        chk("over_state", 32'(game_state), M_OVER);
        repeat (5) tick();
        press_release();
        chk("attract_state", 32'(game_state), M_ATTRACT);
        chk("attract_lives", 32'(lives), 0);
        press_pause();
        chk("attract_pause", 32'(paused), 0);

        // Climb to the top level.
        press_release();
        press_release();
        for (int k = 0; k < 15; k++) begin
            block_state = '0; tick(); block_state = rand_blocks();
            frames_while_state(M_CLEAR, 2, 200, n);
            chk("clear_frames", 32'(n), LEVEL_D);
            press_release();
        end
        chk("top_level", 32'(level), 15);
        lives_before = int'(lives);
        block_state = '0; ball_lost = 1'b1; tick();
        block_state = rand_blocks(); ball_lost = 1'b0;
        chk("tie_state", 32'(game_state), M_CLEAR);
        chk("tie_lives", 32'(lives), 32'(lives_before));
        frames_while_state(M_CLEAR, 2, 200, n);
        chk("sat_frames", 32'(n), LEVEL_D);
        chk("sat_reload", 32'(reload_blocks), 1);
        chk("sat_respawn", 32'(respawn_ball), 1);
        chk("sat_level", 32'(level), 15);

        // Reset in the middle of an update window.
        press_release();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0; tick();
        chk("rst_mid_active", 32'(update_active), 0);
        rst_n = 1'b1;

        // Randomized phase.
        for (int i = 0; i < 25000; i++) begin
            frame_start = ($urandom_range(99) < 20);
            ball_lost   = ($urandom_range(999) < 4);
            if ($urandom_range(999) < 3) block_state = '0;
            else if ($urandom_range(99) < 5) block_state = rand_blocks();
            if ($urandom_range(99) < 3) btn_release = ~btn_release;
            if ($urandom_range(99) < 1) btn_pause = ~btn_pause;
            rst_n = ($urandom_range(4999) != 0);
            tick();
            if (block_state == '0) block_state = rand_blocks();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Top-level sequencer for the breakout game. It converts the VGA frame pulse into the per-frame update window for the game logic. It tracks lives and level and runs the attract / serve / play / lost / level-clear / game-over flow. It also issues the reload and respawn commands that re-initialise the blocks and the ball.

## Interface
- STEPS_PER_FRAME, 12: length of the game-logic update window in cycles.
- LIVES_INIT, 3: lives loaded at new game; legal range 1..3.
- LOST_DELAY_FRAMES, 60: frames frozen after a lost ball; legal range 1..255.
- LEVEL_DELAY_FRAMES, 90: frames frozen after clearing all blocks; legal range 1..255.
- MAX_LEVEL, 15: LEVEL saturates here; legal range 0..15.
- CLK  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  reset; synchronous and active-low.
- FRAME_START  in  1  one-cycle pulse, once per video frame, at start of vertical blanking.
- BTN_RELEASE  in  1  debounced level; rising edge is used.
- BTN_PAUSE  in  1  debounced level; rising edge is used.
- BALL_LOST  in  1  one-cycle pulse from game logic when the ball passes the paddle.
- BLOCK_STATE  in  72  live block bitmap; all-zero means the level is cleared.
- START_UPDATE  out  1  one-cycle pulse that starts a game-logic update.
- UPDATE_ACTIVE  out  1  high for exactly STEPS_PER_FRAME cycles after each START_UPDATE.
- RELOAD_BLOCKS  out  1  one-cycle pulse that restores the initial block pattern.
- RESPAWN_BALL  out  1  one-cycle pulse that puts the ball back on the paddle, waiting for release.
- LIVES  out  2  remaining lives.
- LEVEL  out  4  current level, 0-based.
- GAME_STATE  out  3  encoding: 0 ATTRACT, 1 SERVE, 2 PLAY, 3 LOST_WAIT, 4 LEVEL_CLEAR, 5 GAME_OVER.
- PAUSED  out  1  pause flag.
- FRAME_COUNT  out  16  free-running frame counter, used as a randomness seed; wraps 0xFFFF->0.

## Operation
- Button edges: each button has a registered previous value, reset to 1. Edge = current AND NOT previous. A button held through reset therefore produces no edge.
- FRAME_COUNT increments on every FRAME_START in all states.
- Update scheduling:
  - FRAME_START in SERVE or PLAY, with PAUSED=0 and no window open, gives START_UPDATE on the next cycle.
  - FRAME_START while a window is open is dropped.
- State transitions:
  - ATTRACT: release edge pulses RELOAD_BLOCKS and RESPAWN_BALL, loads LIVES=LIVES_INIT and LEVEL=0, then goes to SERVE.
  - SERVE: release edge goes to PLAY. The game logic launches the ball on the same button.
  - PLAY, BALL_LOST with LIVES=1: LIVES becomes 0, go to GAME_OVER.
  - PLAY, BALL_LOST with LIVES>1: LIVES decrements, delay counter loads LOST_DELAY_FRAMES, go to LOST_WAIT.
  - PLAY, BLOCK_STATE==0: delay counter loads LEVEL_DELAY_FRAMES, go to LEVEL_CLEAR.
  - PLAY, BALL_LOST and empty BLOCK_STATE in the same cycle: LEVEL_CLEAR wins and no life is lost.
  - LOST_WAIT: each FRAME_START decrements the delay counter. On the FRAME_START where it reaches 0, pulse RESPAWN_BALL and go to SERVE.
  - LEVEL_CLEAR: same countdown. At 0, pulse RELOAD_BLOCKS and RESPAWN_BALL, do LEVEL = min(LEVEL+1, MAX_LEVEL), go to SERVE.
  - GAME_OVER: release edge goes to ATTRACT. LIVES and LEVEL hold their values for display.
- Pause:
  - A pause edge toggles PAUSED only in SERVE or PLAY; it is ignored in all other states.
  - PAUSED clears on any transition out of SERVE or PLAY.
  - While PAUSED=1, BALL_LOST and the empty-block check are still honoured. Both inputs are inert without updates.
- A release edge while PAUSED=1 is ignored.
- Delay counter is 8 bits.

## Timing
- Reset (RST_N=0 at an edge) sets, on that edge:
  - GAME_STATE=ATTRACT, PAUSED=0, LIVES=LIVES_INIT, LEVEL=0, FRAME_COUNT=0.
  - All pulse outputs 0, UPDATE_ACTIVE=0, delay counter 0, previous-button registers 1.
- Reset mid-window aborts the window immediately.
- FRAME_START is sampled at edge N: START_UPDATE is high in cycle N+1, and UPDATE_ACTIVE is high in cycles N+2 .. N+1+STEPS_PER_FRAME.
- A new START_UPDATE is possible no earlier than the cycle after UPDATE_ACTIVE falls.
- State-change outputs register one cycle after the triggering input:
  - RELOAD_BLOCKS, RESPAWN_BALL, LIVES, LEVEL and GAME_STATE all update in that same cycle.
  - All pulses are exactly one cycle wide.
- A window already open when the state leaves SERVE or PLAY completes normally.

## Test plan
- Reset with BTN_RELEASE held high, then release held 5 frames -> state stays ATTRACT, no pulses. Then drop and raise release -> RELOAD_BLOCKS and RESPAWN_BALL pulse once, LIVES=3, state SERVE.
- In PLAY, FRAME_START at cycle 100 -> START_UPDATE at 101, UPDATE_ACTIVE high 102..113. Second FRAME_START at 105 -> ignored.
- LIVES=3, BALL_LOST -> LIVES=2, LOST_WAIT, no START_UPDATE for 60 frames. On the 60th FRAME_START -> RESPAWN_BALL, SERVE.
- LIVES=1, BALL_LOST -> LIVES=0, GAME_OVER. Release edge -> ATTRACT with LIVES still 0.
- BLOCK_STATE forced to 0 in the same cycle as BALL_LOST, LEVEL=15 -> LEVEL_CLEAR, LIVES unchanged. After 90 frames -> RELOAD_BLOCKS and RESPAWN_BALL, LEVEL stays 15.
- Pause edge in PLAY -> PAUSED=1, 10 frames give no START_UPDATE. Second edge -> updates resume on the next FRAME_START. Pause edge in ATTRACT -> PAUSED stays 0.
